dma_sequencer_n: RTL and testbench

Parametrised N-channel DMA request sequencer sitting between the DMA end-users (SD/SPI loaders, audio fetch, CPU-side movers) and the single DMA controller port. It arbitrates per-transfer `req/ack/end` handshakes from up to `DEVNUM` users onto one controller interface. It supports round-robin or fixed-priority selection, bursts of up to `BURST` back-to-back transfers per grant, per-channel enable masking, and round-robin fairness that persists across idle periods.

---
 rtl/dma_sequencer_n.sv | 184 ++++++++++++++++++
 tb/tb_dma_sequencer_n.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_sequencer_n.sv
// -----------------------------------------------------------------------------
// dma_sequencer_n
//
// Funnels per-transfer req/ack/end handshakes from up to DEVNUM DMA users onto
// the single DMA controller port. It uses round-robin or fixed-priority
// selection, supports bursts of up to BURST acknowledged transfers per grant,
// and masks channels per channel with chan_en.
//
// Parameters
//   DEVNUM    : number of user channels (2..16)
//   AW / DW   : address / data width
//   BURST     : acks per grant before forced re-arbitration (>= 1)
//   PRIO_MODE : 0 = round-robin, 1 = fixed priority (lowest index wins)
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   req, rnw, chan_en     : per-channel request, direction, enable
//   addr, wd              : flattened per-channel address / write data
//   ack, done             : per-channel acknowledge / end strobes
//   rd                    : read data, broadcast to all users
//   grant, busy           : current input selection, controller ownership
//   dma_req/addr/rnw/wd   : request side of the controller port
//   dma_rd/ack/end        : response side of the controller port
// -----------------------------------------------------------------------------
module dma_sequencer_n #(
    parameter int DEVNUM    = 4,
    parameter int AW        = 22,
    parameter int DW        = 8,
    parameter int BURST     = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DEVNUM-1:0]    req,
    input  logic [DEVNUM*AW-1:0] addr,
    input  logic [DEVNUM-1:0]    rnw,
    input  logic [DEVNUM*DW-1:0] wd,
    input  logic [DEVNUM-1:0]    chan_en,
    output logic [DEVNUM-1:0]    ack,
    output logic [DEVNUM-1:0]    done,
    output logic [DW-1:0]        rd,
    output logic [DEVNUM-1:0]    grant,
    output logic                 busy,
    output logic                 dma_req,
    output logic [AW-1:0]        dma_addr,
    output logic                 dma_rnw,
    output logic [DW-1:0]        dma_wd,
    input  logic [DW-1:0]        dma_rd,
    input  logic                 dma_ack,
    input  logic                 dma_end
);

    // Burst counter width: max(1, clog2(BURST)).
    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

    // The sequencer state is a single bit: it either owns the controller or not.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [DEVNUM-1:0] r_cur_in;   // current input selection (grant)
    logic [DEVNUM-1:0] r_cur_out;  // owner of the transfer last acknowledged
    logic [DEVNUM-1:0] r_last;     // round-robin pointer, one-hot
    logic              r_busy;
    logic [CW-1:0]     r_cnt;

    // ------------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------------
    logic [DEVNUM-1:0] w_elig;
    logic [DEVNUM-1:0] w_upto_last;  // bits 0..last set
    logic [DEVNUM-1:0] w_elig_hi;    // eligible channels strictly above last
    logic [DEVNUM-1:0] w_pick_src;
    logic [DEVNUM-1:0] w_arb;

    assign w_elig = req & chan_en;

    // When last is the top bit the shift overflows to zero and the subtraction
    // wraps to all ones, so nothing counts as "above last" and the scan wraps.
    assign w_upto_last = (r_last << 1) - DEVNUM'(1);
    assign w_elig_hi   = w_elig & ~w_upto_last;

    // Round-robin: prefer the channels above last; otherwise wrap to the lowest
    // eligible one, which is last itself only when it is the sole requester.
    assign w_pick_src = (PRIO_MODE != 0) ? w_elig
                      : ((|w_elig_hi) ? w_elig_hi : w_elig);

    // Isolate the lowest set bit; zero in gives zero out.
    assign w_arb = w_pick_src & (~w_pick_src + DEVNUM'(1));

    // ------------------------------------------------------------------------
    // Input mux (AND-OR select by r_cur_in, all zero when nothing selected)
    // ------------------------------------------------------------------------
    logic [AW-1:0][DEVNUM-1:0] w_addr_col;
    logic [DW-1:0][DEVNUM-1:0] w_wd_col;

    for (genvar b = 0; b < AW; b++) begin : g_addr_bit
        for (genvar i = 0; i < DEVNUM; i++) begin : g_addr_ch
            assign w_addr_col[b][i] = addr[i*AW + b] & r_cur_in[i];
        end
        assign dma_addr[b] = |w_addr_col[b];
    end

    for (genvar b = 0; b < DW; b++) begin : g_wd_bit
        for (genvar i = 0; i < DEVNUM; i++) begin : g_wd_ch
            assign w_wd_col[b][i] = wd[i*DW + b] & r_cur_in[i];
        end
        assign dma_wd[b] = |w_wd_col[b];
    end

    // With no selection the controller sees a harmless read.
    assign dma_rnw = ~(|r_cur_in) | (|(r_cur_in & rnw));
    assign dma_req = |(r_cur_in & req);

    // ------------------------------------------------------------------------
    // Demux and status
    // ------------------------------------------------------------------------
    // done follows r_cur_out, so a dma_end coinciding with dma_ack belongs to
    // the previous transfer's owner.
    assign ack   = r_cur_in  & {DEVNUM{dma_ack}};
    assign done  = r_cur_out & {DEVNUM{dma_end}};
    assign rd    = dma_rd;
    assign grant = r_cur_in;
    assign busy  = r_busy;

    logic w_cur_en;
    logic w_rearb;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned and no latch is inferred.
        w_cur_en = |(r_cur_in & chan_en);
        w_rearb  = 1'b0;
        if ((r_cnt == CNT_LAST) || !w_cur_en) begin
            w_rearb = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    // NOTE: all state, including the round-robin pointer, is cleared by the
    // asynchronous reset so ack/done drop the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_in  <= '0;
            r_cur_out <= '0;
            r_last    <= {1'b1, {(DEVNUM-1){1'b0}}};
            r_busy    <= ST_IDLE;
            r_cnt     <= '0;
        end else if (r_busy == ST_IDLE) begin
            // NOTE: non-blocking assignments keep every register update in this
            // block based on the pre-edge values.
            r_cur_in <= w_arb;
            r_busy   <= (|w_elig) ? ST_BUSY : ST_IDLE;
            r_cnt    <= '0;
            if (|w_elig) begin
                r_last <= w_arb;
            end
        end else begin
            r_busy <= dma_req ? ST_BUSY : ST_IDLE;
            if (dma_ack) begin
                r_cur_out <= r_cur_in;
                if (w_rearb) begin
                    r_cur_in <= w_arb;
                    r_cnt    <= '0;
                    if (|w_arb) begin
                        r_last <= w_arb;
                    end
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end
            // The granted user let go: leave with a fresh burst count.
            if (!dma_req) begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dma_sequencer_n.sv
module tb_dma_sequencer_n;

    localparam logic [21:0] A0 = 22'h10005;
    localparam logic [21:0] A1 = 22'h20016;
    localparam logic [21:0] A2 = 22'h30027;
    localparam logic [21:0] A3 = 22'h3F038;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [87:0] addr = {A3, A2, A1, A0};
    logic [3:0]  rnw = 4'b0101;
    logic [31:0] wd = {8'h44, 8'h33, 8'h22, 8'h11};
    logic [3:0]  chan_en = 4'hF;
    logic [7:0]  dma_rd = 8'h5A;
    logic        dma_ack = 1'b0;
    logic        dma_end = 1'b0;

    // Round-robin, BURST=1
    logic [3:0]  rr_ack, rr_done, rr_grant;
    logic [7:0]  rr_rd, rr_wd;
    logic        rr_busy, rr_req, rr_rnw;
    logic [21:0] rr_addr;
    // Round-robin, BURST=4
    logic [3:0]  bu_ack, bu_done, bu_grant;
    logic [7:0]  bu_rd, bu_wd;
    logic        bu_busy, bu_req, bu_rnw;
    logic [21:0] bu_addr;
    // Fixed priority, BURST=1
    logic [3:0]  fx_ack, fx_done, fx_grant;
    logic [7:0]  fx_rd, fx_wd;
    logic        fx_busy, fx_req, fx_rnw;
    logic [21:0] fx_addr;

    dma_sequencer_n #(.DEVNUM(4), .AW(22), .DW(8), .BURST(1), .PRIO_MODE(0)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .rnw(rnw), .wd(wd),
        .chan_en(chan_en), .ack(rr_ack), .done(rr_done), .rd(rr_rd),
        .grant(rr_grant), .busy(rr_busy), .dma_req(rr_req), .dma_addr(rr_addr),
        .dma_rnw(rr_rnw), .dma_wd(rr_wd), .dma_rd(dma_rd), .dma_ack(dma_ack),
        .dma_end(dma_end));

    dma_sequencer_n #(.DEVNUM(4), .AW(22), .DW(8), .BURST(4), .PRIO_MODE(0)) u_bu (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .rnw(rnw), .wd(wd),
        .chan_en(chan_en), .ack(bu_ack), .done(bu_done), .rd(bu_rd),
        .grant(bu_grant), .busy(bu_busy), .dma_req(bu_req), .dma_addr(bu_addr),
        .dma_rnw(bu_rnw), .dma_wd(bu_wd), .dma_rd(dma_rd), .dma_ack(dma_ack),
        .dma_end(dma_end));

    dma_sequencer_n #(.DEVNUM(4), .AW(22), .DW(8), .BURST(1), .PRIO_MODE(1)) u_fx (
        .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .rnw(rnw), .wd(wd),
        .chan_en(chan_en), .ack(fx_ack), .done(fx_done), .rd(fx_rd),
        .grant(fx_grant), .busy(fx_busy), .dma_req(fx_req), .dma_addr(fx_addr),
        .dma_rnw(fx_rnw), .dma_wd(fx_wd), .dma_rd(dma_rd), .dma_ack(dma_ack),
        .dma_end(dma_end));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n   = 1'b0;
        req     = '0;
        chan_en = 4'hF;
        dma_ack = 1'b0;
        dma_end = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [3:0]  ack;
        logic [21:0] addr;
        logic [3:0]  done;
    } sb_t;

    sb_t sbq[$];
    int  sb_sel = 0;   // 0 = u_rr, 1 = u_bu, 2 = u_fx
    bit  sb_on  = 1'b0;

    always @(negedge clk) begin
        if (sb_on && dma_ack) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: ack seen with no expected entry");
            end else begin
                sb_t e;
                logic [3:0]  a_ack, a_done;
                logic [21:0] a_addr;
                e = sbq.pop_front();
                case (sb_sel)
                    1:       begin a_ack = bu_ack; a_addr = bu_addr; a_done = bu_done; end
                    2:       begin a_ack = fx_ack; a_addr = fx_addr; a_done = fx_done; end
                    default: begin a_ack = rr_ack; a_addr = rr_addr; a_done = rr_done; end
                endcase
                check("sb_ack",  32'(a_ack),  32'(e.ack));
                check("sb_addr", 32'(a_addr), 32'(e.addr));
                check("sb_done", 32'(a_done), 32'(e.done));
            end
        end
    end

    // One dma_ack cycle; back-to-back calls give consecutive acks.
    task automatic pulse_ack(input logic [3:0] e_ack, input logic [21:0] e_addr,
                             input logic [3:0] e_done, input logic with_end);
        sb_t e;
        e.ack  = e_ack;
        e.addr = e_addr;
        e.done = e_done;
        sbq.push_back(e);
        dma_ack = 1'b1;
        dma_end = with_end;
        step();
        dma_ack = 1'b0;
        dma_end = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0]  req;
        logic [3:0]  en;
        logic        dack;
        logic        dend;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic        e_dreq;
        logic [3:0]  e_ack;
        logic [3:0]  e_done;
        logic [21:0] e_addr;
        logic        e_rnw;
        logic [7:0]  e_wd;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        //            req      en    ack   end   grant   busy  dreq  ack      done     addr   rnw   wd
        tbl[0] = '{4'b0100, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 22'h0, 1'b1, 8'h00};
        tbl[1] = '{4'b0100, 4'hF, 1'b0, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0000, 4'b0000, A2,    1'b1, 8'h33};
        tbl[2] = '{4'b0100, 4'hF, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 4'b0100, 4'b0000, A2,    1'b1, 8'h33};
        tbl[3] = '{4'b0000, 4'hF, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b0, 4'b0000, 4'b0100, A2,    1'b1, 8'h33};
        tbl[4] = '{4'b0000, 4'hF, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000, A2,    1'b1, 8'h33};
        tbl[5] = '{4'b0000, 4'hF, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 22'h0, 1'b1, 8'h00};
        tbl[6] = '{4'b0000, 4'hF, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0100, 22'h0, 1'b1, 8'h00};

        // ---- reset state ----
        do_reset();
        check("rst_rr_grant", 32'(rr_grant), 32'h0);
        check("rst_rr_busy",  32'(rr_busy),  32'h0);
        check("rst_rr_rnw",   32'(rr_rnw),   32'h1);
        check("rst_rr_addr",  32'(rr_addr),  32'h0);
        check("rst_bu_grant", 32'(bu_grant), 32'h0);
        check("rst_fx_busy",  32'(fx_busy),  32'h0);
        check("rd_bcast",     32'(rr_rd),    32'h5A);

        // ---- single request on channel 2, cycle by cycle ----
        for (int r = 0; r < 7; r++) begin
            req     = tbl[r].req;
            chan_en = tbl[r].en;
            dma_ack = tbl[r].dack;
            dma_end = tbl[r].dend;
            #1;
            check($sformatf("v%0d_grant", r), 32'(rr_grant), 32'(tbl[r].e_grant));
            check($sformatf("v%0d_busy",  r), 32'(rr_busy),  32'(tbl[r].e_busy));
            check($sformatf("v%0d_dreq",  r), 32'(rr_req),   32'(tbl[r].e_dreq));
            check($sformatf("v%0d_ack",   r), 32'(rr_ack),   32'(tbl[r].e_ack));
            check($sformatf("v%0d_done",  r), 32'(rr_done),  32'(tbl[r].e_done));
            check($sformatf("v%0d_addr",  r), 32'(rr_addr),  32'(tbl[r].e_addr));
            check($sformatf("v%0d_rnw",   r), 32'(rr_rnw),   32'(tbl[r].e_rnw));
            check($sformatf("v%0d_wd",    r), 32'(rr_wd),    32'(tbl[r].e_wd));
            step();
        end
        dma_ack = 1'b0;
        dma_end = 1'b0;

        // ---- round-robin fairness, ack+end together each time ----
        do_reset();
        sb_sel = 0;
        sb_on  = 1'b1;
        req    = 4'hF;
        step();
        check("rr_first_grant", 32'(rr_grant), 32'h1);
        pulse_ack(4'b0001, A0, 4'b0000, 1'b1);
        pulse_ack(4'b0010, A1, 4'b0001, 1'b1);
        pulse_ack(4'b0100, A2, 4'b0010, 1'b1);
        pulse_ack(4'b1000, A3, 4'b0100, 1'b1);
        #1;
        check("rr_wrap_grant", 32'(rr_grant), 32'h1);
        req = 4'h0;
        step();
        step();
        check("rr_idle_busy", 32'(rr_busy), 32'h0);
        req = 4'hF;
        step();
        check("rr_resume_grant", 32'(rr_grant), 32'h2);

        // ---- burst of 4 on channels 0 and 1, then masking ----
        do_reset();
        sb_sel = 1;
        req    = 4'b0011;
        step();
        check("bu_first_grant", 32'(bu_grant), 32'h1);
        for (int k = 0; k < 4; k++) pulse_ack(4'b0001, A0, 4'b0000, 1'b0);
        for (int k = 0; k < 4; k++) pulse_ack(4'b0010, A1, 4'b0000, 1'b0);
        #1;
        check("bu_back_to_0", 32'(bu_grant), 32'h1);
        for (int k = 0; k < 4; k++) pulse_ack(4'b0001, A0, 4'b0000, 1'b0);
        pulse_ack(4'b0010, A1, 4'b0000, 1'b0);
        chan_en = 4'b1101;
        #1;
        check("mask_hold_grant", 32'(bu_grant), 32'h2);
        check("mask_hold_dreq",  32'(bu_req),   32'h1);
        pulse_ack(4'b0010, A1, 4'b0000, 1'b0);
        #1;
        check("mask_regrant", 32'(bu_grant), 32'h1);
        chan_en = 4'b0000;
        pulse_ack(4'b0001, A0, 4'b0000, 1'b0);
        #1;
        check("mask_all_dreq", 32'(bu_req),   32'h0);
        check("mask_all_rnw",  32'(bu_rnw),   32'h1);
        check("mask_all_addr", 32'(bu_addr),  32'h0);
        step();
        check("mask_all_busy", 32'(bu_busy),  32'h0);
        chan_en = 4'hF;

        // ---- fixed priority ----
        do_reset();
        sb_sel = 2;
        req    = 4'b1010;
        step();
        check("fx_first_grant", 32'(fx_grant), 32'h2);
        for (int k = 0; k < 3; k++) pulse_ack(4'b0010, A1, 4'b0000, 1'b0);
        req = 4'b1000;
        step();
        step();
        check("fx_grant_3", 32'(fx_grant), 32'h8);
        check("fx_addr_3",  32'(fx_addr),  32'(A3));
        check("fx_dreq_3",  32'(fx_req),   32'h1);
        sb_on = 1'b0;
        check("sb_drained", 32'(sbq.size()), 32'h0);

        // ---- reset in the middle of a transfer ----
        do_reset();
        req = 4'b0100;
        step();
        dma_ack = 1'b1;
        step();
        dma_end = 1'b1;
        #1;
        check("mid_ack_before",  32'(rr_ack),  32'h4);
        check("mid_done_before", 32'(rr_done), 32'h4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", 32'(rr_grant), 32'h0);
        check("mid_rst_busy",  32'(rr_busy),  32'h0);
        check("mid_rst_ack",   32'(rr_ack),   32'h0);
        check("mid_rst_done",  32'(rr_done),  32'h0);
        dma_ack = 1'b0;
        dma_end = 1'b0;
        req     = 4'hF;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("post_rst_grant", 32'(rr_grant), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
